// File: rtl/conv11_pkg.sv
// ---------------------------------------------------------------------------
// conv11_pkg : shared widths, FSM state type and round/saturate helper
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv11_pkg;

  localparam int ACC_WIDTH   = 32;
  localparam int SCALE_WIDTH = 24;
  localparam int OUT_WIDTH   = 8;
  localparam int SHIFT       = 16;
  localparam int PROD_WIDTH  = ACC_WIDTH + SCALE_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Round-half-up arithmetic shift followed by optional ReLU and clamp.
  function automatic logic signed [OUT_WIDTH-1:0] round_sat(
    input logic signed [PROD_WIDTH-1:0] prod,
    input logic                         relu
  );
    logic signed [PROD_WIDTH-1:0] half;
    logic signed [PROD_WIDTH-1:0] hi;
    logic signed [PROD_WIDTH-1:0] lo;
    logic signed [PROD_WIDTH-1:0] rnd;
    half = PROD_WIDTH'((64'd1 << SHIFT) >> 1);
    hi   = PROD_WIDTH'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
    lo   = ~hi;
    rnd  = (prod + half) >>> SHIFT;
    if (relu && rnd[PROD_WIDTH-1]) return '0;
    if (rnd > hi)                  return hi[OUT_WIDTH-1:0];
    if (rnd < lo)                  return lo[OUT_WIDTH-1:0];
    return rnd[OUT_WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv11_requant_if.sv
// ---------------------------------------------------------------------------
// conv11_requant_if : control, scale-fetch, accumulator and result signals
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface conv11_requant_if #(
  parameter int ACC_WIDTH   = conv11_pkg::ACC_WIDTH,
  parameter int SCALE_WIDTH = conv11_pkg::SCALE_WIDTH,
  parameter int OUT_WIDTH   = conv11_pkg::OUT_WIDTH,
  parameter int CH_W        = 3
);

  logic                        start;
  logic                        scale_rd_en;
  logic [SCALE_WIDTH-1:0]      scale_in;
  logic                        scale_valid;
  logic signed [ACC_WIDTH-1:0] acc_in;
  logic                        acc_valid;
  logic                        acc_ready;
  logic signed [OUT_WIDTH-1:0] data_out;
  logic                        out_valid;
  logic [CH_W-1:0]             ch_idx;
  logic                        busy;
  logic                        done;

  modport master (
    output start, scale_in, scale_valid, acc_in, acc_valid,
    input  scale_rd_en, acc_ready, data_out, out_valid, ch_idx, busy, done
  );

  modport slave (
    input  start, scale_in, scale_valid, acc_in, acc_valid,
    output scale_rd_en, acc_ready, data_out, out_valid, ch_idx, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/conv11_requant_pipe.sv
// ---------------------------------------------------------------------------
// conv11_requant_pipe : 3-stage multiply / round-shift / saturate datapath
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv11_requant_pipe #(
  parameter int ACC_WIDTH   = conv11_pkg::ACC_WIDTH,
  parameter int SCALE_WIDTH = conv11_pkg::SCALE_WIDTH,
  parameter int OUT_WIDTH   = conv11_pkg::OUT_WIDTH,
  parameter int SHIFT       = conv11_pkg::SHIFT,
  parameter int RELU_EN     = 1,
  parameter int CH_W        = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic [SCALE_WIDTH-1:0]      scale_i,
  input  logic [CH_W-1:0]             ch_i,
  output logic                        out_valid_o,
  output logic signed [OUT_WIDTH-1:0] data_o,
  output logic [CH_W-1:0]             ch_o,
  output logic                        busy_o
);

  localparam int c_PROD_W = ACC_WIDTH + SCALE_WIDTH + 1;
  localparam logic signed [c_PROD_W-1:0] c_RND_HALF = c_PROD_W'((64'd1 << SHIFT) >> 1);
  localparam logic signed [c_PROD_W-1:0] c_OUT_MAX  = c_PROD_W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [c_PROD_W-1:0] c_OUT_MIN  = ~c_OUT_MAX;

  logic                        s1_valid_q, s2_valid_q, s3_valid_q;
  logic [CH_W-1:0]             s1_ch_q, s2_ch_q, s3_ch_q;
  logic signed [c_PROD_W-1:0]  s1_prod_q, s2_rnd_q;
  logic signed [OUT_WIDTH-1:0] s3_data_q;

  logic signed [c_PROD_W-1:0]  acc_ext, scale_ext, prod_d, rnd_d;
  logic signed [OUT_WIDTH-1:0] sat_d;

  // Scale is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    acc_ext   = c_PROD_W'(acc_i);
    scale_ext = $signed(c_PROD_W'(scale_i));
    prod_d    = acc_ext * scale_ext;
    rnd_d     = (s1_prod_q + c_RND_HALF) >>> SHIFT;
    sat_d     = s2_rnd_q[OUT_WIDTH-1:0];
    if ((RELU_EN != 0) && s2_rnd_q[c_PROD_W-1]) begin
      sat_d = '0;
    end else if (s2_rnd_q > c_OUT_MAX) begin
      sat_d = c_OUT_MAX[OUT_WIDTH-1:0];
    end else if (s2_rnd_q < c_OUT_MIN) begin
      sat_d = c_OUT_MIN[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s2_ch_q    <= '0;
      s3_ch_q    <= '0;
      s1_prod_q  <= '0;
      s2_rnd_q   <= '0;
      s3_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (in_valid_i) begin
        s1_prod_q <= prod_d;
        s1_ch_q   <= ch_i;
      end
      if (s1_valid_q) begin
        s2_rnd_q <= rnd_d;
        s2_ch_q  <= s1_ch_q;
      end
      if (s2_valid_q) begin
        s3_data_q <= sat_d;
        s3_ch_q   <= s2_ch_q;
      end
    end
  end

  assign out_valid_o = s3_valid_q;
  assign data_o      = s3_data_q;
  assign ch_o        = s3_ch_q;
  assign busy_o      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

`default_nettype wire

// File: rtl/conv11_requant.sv
// ---------------------------------------------------------------------------
// conv11_requant : per-channel scale fetch FSM driving the requant pipeline
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv11_requant #(
  parameter int ACC_WIDTH   = conv11_pkg::ACC_WIDTH,
  parameter int SCALE_WIDTH = conv11_pkg::SCALE_WIDTH,
  parameter int OUT_WIDTH   = conv11_pkg::OUT_WIDTH,
  parameter int SHIFT       = conv11_pkg::SHIFT,
  parameter int PIX_COUNT   = 16,
  parameter int CH_COUNT    = 8,
  parameter int RELU_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  conv11_requant_if.slave  bus
);

  import conv11_pkg::*;

  localparam int c_PIX_W = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;
  localparam int c_CH_W  = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

  state_e                 state_q, state_d;
  logic [c_PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [c_CH_W-1:0]      ch_cnt_q, ch_cnt_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;

  logic w_xfer;
  logic w_pipe_busy;

  assign w_xfer = (state_q == ST_RUN) && bus.acc_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      ch_cnt_q  <= '0;
      scale_q   <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      ch_cnt_q  <= ch_cnt_d;
      scale_q   <= scale_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pix_cnt_d       = pix_cnt_q;
    ch_cnt_d        = ch_cnt_q;
    scale_d         = scale_q;
    bus.scale_rd_en = 1'b0;
    bus.acc_ready   = 1'b0;
    bus.done        = 1'b0;
    bus.busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pix_cnt_d = '0;
          ch_cnt_d  = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.scale_rd_en = 1'b1;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.scale_valid) begin
          scale_d = bus.scale_in;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.acc_ready = 1'b1;
        if (bus.acc_valid) begin
          if (pix_cnt_q == c_PIX_W'(PIX_COUNT - 1)) begin
            pix_cnt_d = '0;
            if (ch_cnt_q == c_CH_W'(CH_COUNT - 1)) begin
              state_d = ST_DRAIN;
            end else begin
              ch_cnt_d = ch_cnt_q + c_CH_W'(1);
              state_d  = ST_REQ;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + c_PIX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // done lands on the cycle right after the final result leaves stage 3
        if (!w_pipe_busy) begin
          bus.done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  conv11_requant_pipe #(
    .ACC_WIDTH   (ACC_WIDTH),
    .SCALE_WIDTH (SCALE_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT       (SHIFT),
    .RELU_EN     (RELU_EN),
    .CH_W        (c_CH_W)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (w_xfer),
    .acc_i       (bus.acc_in),
    .scale_i     (scale_q),
    .ch_i        (ch_cnt_q),
    .out_valid_o (bus.out_valid),
    .data_o      (bus.data_out),
    .ch_o        (bus.ch_idx),
    .busy_o      (w_pipe_busy)
  );

endmodule

`default_nettype wire

// File: tb/tb_conv11_requant.sv
// ---------------------------------------------------------------------------
// tb_conv11_requant : directed bench for conv11_requant (2x4 pass and ReLU pass)
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv11_requant;

  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  conv11_requant_if #(.CH_W(1)) bus_a ();
  conv11_requant_if #(.CH_W(1)) bus_b ();

  conv11_requant #(.PIX_COUNT(4), .CH_COUNT(2), .RELU_EN(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  conv11_requant #(.PIX_COUNT(2), .CH_COUNT(1), .RELU_EN(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rd  = 0;
  int n_done = 0;
  int done_t = 0;
  int first_t = 0;
  int obs_d[$], obs_c[$], obs_t[$];
  int exp_d[$], exp_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every result of dut_a with the index of the edge it is sampled on.
  always @(negedge clk) begin
    if (bus_a.out_valid === 1'b1) begin
      obs_d.push_back(int'($signed(bus_a.data_out)));
      obs_c.push_back(int'(bus_a.ch_idx));
      obs_t.push_back(cyc + 1);
    end
    if (bus_a.scale_rd_en === 1'b1) n_rd++;
    if (bus_a.done === 1'b1) begin
      n_done++;
      done_t = cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp4(input int ch, input int d0, input int d1, input int d2, input int d3);
    exp_d.push_back(d0); exp_d.push_back(d1); exp_d.push_back(d2); exp_d.push_back(d3);
    repeat (4) exp_c.push_back(ch);
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_c.delete(); obs_t.delete();
    exp_d.delete(); exp_c.delete();
    n_rd = 0; n_done = 0; done_t = 0;
  endtask

  task automatic start_a();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    int k = 0;
    while (bus_a.scale_rd_en !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk({tag, "_rd_en"}, bus_a.scale_rd_en, 1);
    chk({tag, "_ready_lo"}, bus_a.acc_ready, 0);
  endtask

  // Entered in the REQ cycle; noisy mode drives start/acc_valid/junk scale while waiting.
  task automatic give_scale(input logic [23:0] scl, input int dly, input bit noisy);
    if (noisy) begin
      bus_a.acc_valid = 1'b1;
      bus_a.acc_in    = 999;
      bus_a.start     = 1'b1;
      bus_a.scale_in  = 24'hABCDEF;
    end
    step();
    for (int i = 0; i < dly; i++) begin
      step();
      chk("wait_ready_lo", bus_a.acc_ready, 0);
      chk("wait_busy", bus_a.busy, 1);
    end
    bus_a.acc_valid   = 1'b0;
    bus_a.start       = 1'b0;
    bus_a.scale_in    = scl;
    bus_a.scale_valid = 1'b1;
    step();
    bus_a.scale_valid = 1'b0;
    bus_a.scale_in    = 24'h5A5A5A;
    chk("run_ready_hi", bus_a.acc_ready, 1);
  endtask

  task automatic xfer(input int v, input bit noisy);
    bus_a.acc_in      = v;
    bus_a.acc_valid   = 1'b1;
    bus_a.start       = noisy;
    bus_a.scale_valid = noisy;
    if (noisy) bus_a.scale_in = 24'h7FFFFF;
    step();
    bus_a.acc_valid   = 1'b0;
    bus_a.start       = 1'b0;
    bus_a.scale_valid = 1'b0;
  endtask

  task automatic finish_pass(input string tag);
    int k = 0;
    while (bus_a.done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_done"}, bus_a.done, 1);
    step();
    chk({tag, "_idle"}, bus_a.busy, 0);
    chk({tag, "_n_done"}, n_done, 1);
    chk({tag, "_n_rd"}, n_rd, 2);
    chk({tag, "_n_out"}, obs_d.size(), exp_d.size());
    if (obs_t.size() > 0) begin
      chk({tag, "_latency"}, obs_t[0] - first_t, 3);
      chk({tag, "_done_t"}, done_t, obs_t[obs_t.size() - 1] + 1);
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), obs_d[i], exp_d[i]);
      chk($sformatf("%s_ch[%0d]", tag, i), obs_c[i], exp_c[i]);
    end
    clear_obs();
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.scale_in = '0; bus_a.scale_valid = 1'b0;
    bus_a.acc_in = '0;  bus_a.acc_valid = 1'b0;
    bus_b.start = 1'b0; bus_b.scale_in = '0; bus_b.scale_valid = 1'b0;
    bus_b.acc_in = '0;  bus_b.acc_valid = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_acc_ready", bus_a.acc_ready, 0);
    chk("rst_rd_en", bus_a.scale_rd_en, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_data", $signed(bus_a.data_out), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    clear_obs();

    // Pass 1: unit scale pass-through and saturation, then half scale rounding
    start_a();
    wait_rd("p1c0");
    give_scale(24'h010000, 0, 1'b0);
    xfer(100, 1'b0); first_t = cyc;
    xfer(-5, 1'b0); xfer(127, 1'b0); xfer(1000, 1'b0);
    exp4(0, 100, -5, 127, 127);
    wait_rd("p1c1");
    give_scale(24'h008000, 0, 1'b0);
    xfer(3, 1'b0); xfer(-3, 1'b0); xfer(5, 1'b0); xfer(-1000, 1'b0);
    exp4(1, 2, -1, 3, -128);
    finish_pass("p1");

    // Pass 2: per-channel scale 1.0 then 2.0
    start_a();
    wait_rd("p2c0");
    give_scale(24'h010000, 0, 1'b0);
    xfer(10, 1'b0); first_t = cyc;
    xfer(10, 1'b0); xfer(10, 1'b0); xfer(10, 1'b0);
    exp4(0, 10, 10, 10, 10);
    wait_rd("p2c1");
    give_scale(24'h020000, 0, 1'b0);
    repeat (4) xfer(10, 1'b0);
    exp4(1, 20, 20, 20, 20);
    finish_pass("p2");

    // Pass 3: late scale, stray start/acc_valid/scale_valid everywhere
    start_a();
    wait_rd("p3c0");
    give_scale(24'h010000, 5, 1'b1);
    xfer(100, 1'b1); first_t = cyc;
    xfer(-5, 1'b1); xfer(127, 1'b1); xfer(-1000, 1'b1);
    exp4(0, 100, -5, 127, -128);
    wait_rd("p3c1");
    give_scale(24'h010000, 0, 1'b0);
    xfer(-1, 1'b1); xfer(0, 1'b1); xfer(1, 1'b1); xfer(-128, 1'b1);
    exp4(1, -1, 0, 1, -128);
    finish_pass("p3");

    // Pass 4: reset with two values in flight
    start_a();
    wait_rd("p4c0");
    give_scale(24'h010000, 0, 1'b0);
    xfer(50, 1'b0); xfer(60, 1'b0);
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    chk("abort_out_valid", bus_a.out_valid, 0);
    chk("abort_busy", bus_a.busy, 0);
    chk("abort_acc_ready", bus_a.acc_ready, 0);
    chk("abort_rd_en", bus_a.scale_rd_en, 0);
    chk("abort_done", bus_a.done, 0);
    chk("abort_data", $signed(bus_a.data_out), 0);
    chk("abort_ch", bus_a.ch_idx, 0);
    repeat (4) step();
    chk("abort_no_out", obs_d.size(), 0);
    clear_obs();

    // Pass 5: full pass after abort, scales 1.0 and 1.5
    start_a();
    wait_rd("p5c0");
    give_scale(24'h010000, 0, 1'b0);
    xfer(7, 1'b0); first_t = cyc;
    xfer(-7, 1'b0); xfer(20, 1'b0); xfer(200, 1'b0);
    exp4(0, 7, -7, 20, 127);
    wait_rd("p5c1");
    give_scale(24'h018000, 0, 1'b0);
    xfer(7, 1'b0); xfer(-7, 1'b0); xfer(20, 1'b0); xfer(-100, 1'b0);
    exp4(1, 11, -10, 30, -128);
    finish_pass("p5");

    // ReLU instance: one channel of two pixels
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int k = 0; k < 10 && bus_b.scale_rd_en !== 1'b1; k++) step();
    chk("relu_rd_en", bus_b.scale_rd_en, 1);
    step();
    bus_b.scale_in    = 24'h010000;
    bus_b.scale_valid = 1'b1;
    step();
    bus_b.scale_valid = 1'b0;
    bus_b.acc_in      = -50;
    bus_b.acc_valid   = 1'b1;
    step();
    bus_b.acc_in      = 50;
    step();
    bus_b.acc_valid   = 1'b0;
    step();
    chk("relu_v0", bus_b.out_valid, 1);
    chk("relu_d0", $signed(bus_b.data_out), 0);
    step();
    chk("relu_v1", bus_b.out_valid, 1);
    chk("relu_d1", $signed(bus_b.data_out), 50);
    step();
    chk("relu_done", bus_b.done, 1);
    chk("relu_v_lo", bus_b.out_valid, 0);
    step();
    chk("relu_idle", bus_b.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
